// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared constants and types for the 4-requester TDP RAM arbiter.
// Holds NREQ/AW/DW, the requester id type, the per-port read tag and a one-hot helper.
package ram_arb_pkg;
  localparam int NREQ = 4;
  localparam int AW = 9;
  localparam int DW = 16;
  typedef logic [1:0] req_id_t;
  typedef struct packed {
    logic    rd;
    req_id_t id;
  } tag_t;
  function automatic logic [NREQ-1:0] onehot(input req_id_t id);
    return NREQ'(1) << id;
  endfunction
endpackage

// File: rtl/ram_arb_tag_pipe.sv
// ram_arb_tag_pipe: two-stage read-tag delay line for one RAM port.
// Ports: clk, rst_n (sync active-low clear), tag_i (tag of this cycle's grant),
//        vld_o (one-hot response strobe, aligned with the RAM's registered output).
module ram_arb_tag_pipe
  import ram_arb_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  tag_t            tag_i,
  output logic [NREQ-1:0] vld_o
);
  tag_t s1_q, s2_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= tag_i;
      s2_q <= s1_q;
    end
  end
  assign vld_o = s2_q.rd ? onehot(s2_q.id) : '0;
endmodule

// File: rtl/ram_tdp_arbiter_4x512x16.sv
// ram_tdp_arbiter_4x512x16: grants up to two of four requesters onto a 512x16 true-dual-port RAM.
// Ports: clk, rst_n (sync active-low); req_valid/req_we/req_addr/req_din in, req_ready out;
//        rsp_valid/rsp_data out (read returns, two cycles after the grant);
//        weA/reA/addrA/dinA, weB/reB/addrB/dinB out and doutA/doutB in (RAM side).
// Build option: RAM_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 highest)
//               instead of round-robin.
module ram_tdp_arbiter_4x512x16
  import ram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_din,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [NREQ*DW-1:0] rsp_data,
  output logic              weA,
  output logic              weB,
  output logic              reA,
  output logic              reB,
  output logic [AW-1:0]      addrA,
  output logic [AW-1:0]      addrB,
  output logic [DW-1:0]      dinA,
  output logic [DW-1:0]      dinB,
  input  logic [DW-1:0]      doutA,
  input  logic [DW-1:0]      doutB
);
  req_id_t         start, id_a, id_b;
  logic            cand_a, cand_b, hazard, gnt_a, gnt_b, we_a, we_b;
  logic [AW-1:0]   addr_a, addr_b;
  logic [NREQ-1:0] vld_a, vld_b;
  tag_t            tag_a, tag_b;
  always_comb begin
    req_id_t idx;
    idx = '0;
    cand_a = 1'b0;
    cand_b = 1'b0;
    id_a = '0;
    id_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = start + req_id_t'(k);
      if (req_valid[idx] && !cand_a) begin
        cand_a = 1'b1;
        id_a = idx;
      end else if (req_valid[idx] && !cand_b) begin
        cand_b = 1'b1;
        id_b = idx;
      end
    end
  end
  assign addr_a = req_addr[id_a*AW +: AW];
  assign addr_b = req_addr[id_b*AW +: AW];
  assign we_a = req_we[id_a];
  assign we_b = req_we[id_b];
  // port B candidate is dropped (never replaced) on a same-address write conflict
  assign hazard = cand_b && addr_a == addr_b && (we_a || we_b);
  assign gnt_a = rst_n && cand_a;
  assign gnt_b = rst_n && cand_b && !hazard;
  assign req_ready = (gnt_a ? onehot(id_a) : '0) | (gnt_b ? onehot(id_b) : '0);
  assign weA = gnt_a && we_a;
  assign reA = gnt_a && !we_a;
  assign weB = gnt_b && we_b;
  assign reB = gnt_b && !we_b;
  assign addrA = gnt_a ? addr_a : '0;
  assign addrB = gnt_b ? addr_b : '0;
  assign dinA = gnt_a ? req_din[id_a*DW +: DW] : '0;
  assign dinB = gnt_b ? req_din[id_b*DW +: DW] : '0;
`ifdef RAM_ARB_FIXED_PRIO_EN
  assign start = '0;
`else
  req_id_t rr_q, rr_d;
  assign rr_d = gnt_b ? id_b + 2'd1 : gnt_a ? id_a + 2'd1 : rr_q;
  always_ff @(posedge clk) begin
    rr_q <= !rst_n ? '0 : rr_d;
  end
  assign start = rr_q;
`endif
  assign tag_a = {reA, id_a};
  assign tag_b = {reB, id_b};
  ram_arb_tag_pipe u_pipe_a (.clk(clk), .rst_n(rst_n), .tag_i(tag_a), .vld_o(vld_a));
  ram_arb_tag_pipe u_pipe_b (.clk(clk), .rst_n(rst_n), .tag_i(tag_b), .vld_o(vld_b));
  always_comb begin
    rsp_valid = rst_n ? (vld_a | vld_b) : '0;
    rsp_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_data[i*DW +: DW] = !rst_n ? '0 : vld_a[i] ? doutA : vld_b[i] ? doutB : '0;
    end
  end
endmodule

// File: tb/tb_ram_tdp_arbiter_4x512x16.sv
// tb_ram_tdp_arbiter_4x512x16: directed and random bench with a behavioural arbiter/memory model.
module tb_ram_tdp_arbiter_4x512x16;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid, req_we, req_ready, rsp_valid;
  logic [35:0] req_addr;
  logic [63:0] req_din, rsp_data;
  logic        weA, weB, reA, reB;
  logic [8:0]  addrA, addrB;
  logic [15:0] dinA, dinB, doutA, doutB;
  logic [3:0]  v = '0, w = '0;
  logic [8:0]  a [4];
  logic [15:0] d [4];
  logic [15:0] ram [512];
  logic [15:0] ra, rb;
  logic [15:0] gold [512];
  logic [3:0]  pv [4];
  logic [15:0] pd [4][4];
  logic [3:0]  hs = '0;
  logic [3:0]  t3 [4];
  logic [53:0] pins;
  int          stall [4];
  int          mrr = 0, cyc = 0, checks = 0, errors = 0;

  always #5 clk = ~clk;

  assign req_valid = v;
  assign req_we = w;
  for (genvar i = 0; i < 4; i++) begin : g_pack
    assign req_addr[i*9 +: 9] = a[i];
    assign req_din[i*16 +: 16] = d[i];
  end
  assign pins = {weA, weB, reA, reB, addrA, addrB, dinA, dinB};

  ram_tdp_arbiter_4x512x16 dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_din(req_din),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .weA(weA), .weB(weB), .reA(reA), .reB(reB),
    .addrA(addrA), .addrB(addrB), .dinA(dinA), .dinB(dinB),
    .doutA(doutA), .doutB(doutB)
  );

  // RAM with array read on the grant edge and an output register one edge later
  always @(posedge clk) begin
    if (weA) ram[addrA] <= dinA;
    if (weB) ram[addrB] <= dinB;
    if (reA) ra <= ram[addrA];
    if (reB) rb <= ram[addrB];
    doutA <= ra;
    doutB <= rb;
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, act, exp, $time);
    end
  endtask

  // Reference: scan order from the model pointer, first two valid win, hazard drops the second;
  // reads return the scoreboard contents two cycles later.
  always @(negedge clk) begin
    int s, f, sc, last;
    logic [3:0] g;
    logic hz, gb;
    s = cyc % 4;
    cyc++;
    if (!rst_n) begin
      chk("rst_hs", {req_ready, rsp_valid}, '0);
      chk("rst_data", rsp_data, '0);
      chk("rst_pins", pins, '0);
      for (int k = 0; k < 4; k++) begin
        pv[k] = '0;
        stall[k] = 0;
      end
      mrr = 0;
      hs = '0;
    end else begin
      f = -1;
      sc = -1;
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (mrr + k) % 4;
        if (v[i]) begin
          if (f < 0) f = i;
          else if (sc < 0) sc = i;
        end
      end
      g = '0;
      gb = 1'b0;
      if (f >= 0) g[f] = 1'b1;
      if (sc >= 0) begin
        gb = !(a[f] == a[sc] && (w[f] || w[sc]));
        if (gb) g[sc] = 1'b1;
      end
`ifndef RAM_ARB_FIXED_PRIO_EN
      if (f >= 0) begin
        last = gb ? sc : f;
        mrr = (last + 1) % 4;
      end
`endif
      chk("ready", req_ready, g);
      chk("rsp_valid", rsp_valid, pv[s]);
      for (int i = 0; i < 4; i++)
        if (pv[s][i]) chk($sformatf("rsp_data%0d", i), rsp_data[i*16 +: 16], pd[s][i]);
      pv[s] = '0;
      for (int i = 0; i < 4; i++)
        if (g[i] && !w[i]) begin
          pv[(s+2)%4][i] = 1'b1;
          pd[(s+2)%4][i] = gold[a[i]];
        end
      for (int i = 0; i < 4; i++)
        if (g[i] && w[i]) gold[a[i]] = d[i];
      hz = (weA || reA) && (weB || reB) && addrA == addrB && (weA || weB);
      chk("hazard_pins", hz, 1'b0);
      for (int i = 0; i < 4; i++) begin
        stall[i] = (v[i] && !req_ready[i]) ? stall[i] + 1 : 0;
`ifndef RAM_ARB_FIXED_PRIO_EN
        if (v[i]) chk($sformatf("starve%0d", i), stall[i] <= 3, 1'b1);
`endif
      end
      hs = req_valid & req_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic set(input int i, input logic we, input logic [8:0] ad, input logic [15:0] dd);
    v[i] = 1'b1;
    w[i] = we;
    a[i] = ad;
    d[i] = dd;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      ram[i] = '0;
      gold[i] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      a[i] = '0;
      d[i] = '0;
      pv[i] = '0;
      stall[i] = 0;
    end
    ra = '0;
    rb = '0;
    doutA = '0;
    doutB = '0;
`ifdef RAM_ARB_FIXED_PRIO_EN
    t3 = '{4'b0011, 4'b0011, 4'b0011, 4'b0011};
`else
    t3 = '{4'b1100, 4'b0011, 4'b1100, 4'b0011};
`endif
    v = 4'hF;
    mid();
    chk("rst_ready_lit", req_ready, 4'b0000);
    tick();
    tick();
    rst_n = 1'b1;
    v = '0;
    set(0, 1'b1, 9'h010, 16'hA5A5);
    set(1, 1'b1, 9'h1F0, 16'h5A5A);
    mid();
    chk("t1_wr_ready", req_ready, 4'b0011);
    tick();
    v = '0;
    tick();
    set(0, 1'b0, 9'h010, 16'h0);
    set(1, 1'b0, 9'h1F0, 16'h0);
    mid();
    chk("t1_rd_ready", req_ready, 4'b0011);
    tick();
    v = '0;
    tick();
    mid();
    chk("t1_rsp_valid", rsp_valid, 4'b0011);
    chk("t1_lane0", rsp_data[15:0], 16'hA5A5);
    chk("t1_lane1", rsp_data[31:16], 16'h5A5A);
    tick();
    set(0, 1'b1, 9'h020, 16'h1234);
    set(1, 1'b0, 9'h020, 16'h0);
    mid();
    chk("t2_hazard_ready", req_ready, 4'b0001);
    tick();
    v[0] = 1'b0;
    mid();
    chk("t2_retry_ready", req_ready, 4'b0010);
    tick();
    v = '0;
    mid();
    chk("t2_rsp_early", rsp_valid, 4'b0000);
    tick();
    mid();
    chk("t2_rsp_valid", rsp_valid, 4'b0010);
    chk("t2_lane1", rsp_data[31:16], 16'h1234);
    tick();
    set(0, 1'b0, 9'h010, 16'h0);
    set(1, 1'b0, 9'h1F0, 16'h0);
    set(2, 1'b0, 9'h020, 16'h0);
    set(3, 1'b0, 9'h030, 16'h0);
    for (int k = 0; k < 4; k++) begin
      mid();
      chk($sformatf("t3_ready%0d", k), req_ready, t3[k]);
      tick();
    end
    v = '0;
    tick();
    tick();
    tick();
    set(2, 1'b0, 9'h020, 16'h0);
    mid();
    chk("t4_ready", req_ready, 4'b0100);
    tick();
    rst_n = 1'b0;
    v = 4'hF;
    mid();
    chk("t4_rst_ready", req_ready, 4'b0000);
    chk("t4_rst_pins", pins, '0);
    tick();
    mid();
    chk("t4_no_rsp", rsp_valid, 4'b0000);
    chk("t4_rst_data", rsp_data, '0);
    tick();
    rst_n = 1'b1;
    v = '0;
    tick();
    set(3, 1'b0, 9'h020, 16'h0);
    mid();
    chk("t4_rd_ready", req_ready, 4'b1000);
    tick();
    v = '0;
    tick();
    mid();
    chk("t4_rsp_valid", rsp_valid, 4'b1000);
    chk("t4_lane3", rsp_data[63:48], 16'h1234);
    for (int n = 0; n < 2560; n++) begin
      tick();
      for (int i = 0; i < 4; i++)
        if (!v[i] || hs[i]) begin
          v[i] = $urandom_range(0, 3) != 0;
          w[i] = 1'($urandom_range(0, 1));
          a[i] = $urandom_range(0, 1) ? 9'($urandom_range(0, 7)) : 9'($urandom_range(0, 511));
          d[i] = 16'($urandom);
        end
    end
    tick();
    v = '0;
    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
